// File: rtl/stack_exec_seq.sv
// Execution sequencer for the 16-bit stack-machine ALU: owns TOS/NEXT and a
// spill stack, accepts stack commands over valid/ready and writes ALU results back.
module stack_exec_seq #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_sel,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] alu_tos,
    output logic [WIDTH-1:0] alu_next,
    output logic [3:0]       alu_select,
    input  logic [WIDTH-1:0] alu_o_tos,
    input  logic [WIDTH-1:0] alu_o_next,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] next,
    output logic [CNT_W-1:0] depth,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int CAP  = DEPTH + 2;
    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP      = 3'b000,
        OP_PUSH     = 3'b001,
        OP_DROP     = 3'b010,
        OP_DUP      = 3'b011,
        OP_SWAP     = 3'b100,
        OP_ALU_POP  = 3'b101,
        OP_ALU_KEEP = 3'b110,
        OP_RSVD     = 3'b111
    } op_t;

    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;
    localparam logic [1:0] ERR_RSVD  = 2'b11;

    state_t           state_q, state_d;
    op_t              op_q;
    logic [3:0]       sel_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] next_q, next_d;
    logic [CNT_W-1:0] depth_q, depth_d;
    logic [SP_W-1:0]  sp_q, sp_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;

    logic [WIDTH-1:0] spill_q [DEPTH];
    logic             spill_we;
    logic [AW-1:0]    spill_wr_idx;
    logic [AW-1:0]    spill_rd_idx;
    logic [WIDTH-1:0] spill_rd;

    logic       accept;
    logic       has_room, ge1, ge2, ge3;
    logic [1:0] chk_code;

    assign has_room     = depth_q < CNT_W'(CAP);
    assign ge1          = depth_q != '0;
    assign ge2          = depth_q >= CNT_W'(2);
    assign ge3          = depth_q >= CNT_W'(3);
    assign accept       = cmd_valid && (state_q == IDLE);
    assign spill_wr_idx = sp_q[AW-1:0];
    assign spill_rd_idx = AW'(sp_q - SP_W'(1));
    assign spill_rd     = spill_q[spill_rd_idx];

    // Depth legality is judged against the depth seen on the accept edge.
    always_comb begin
        chk_code = '0;
        case (cmd_op)
            OP_PUSH:              if (!has_room) chk_code = ERR_OVER;
            OP_DUP: begin
                if (!ge1)           chk_code = ERR_UNDER;
                else if (!has_room) chk_code = ERR_OVER;
            end
            OP_DROP, OP_ALU_KEEP: if (!ge1) chk_code = ERR_UNDER;
            OP_SWAP, OP_ALU_POP:  if (!ge2) chk_code = ERR_UNDER;
            OP_RSVD:              chk_code = ERR_RSVD;
            default:              chk_code = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && chk_code == '0) state_d = EXEC;
            EXEC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
    end

    always_comb begin
        tos_d      = tos_q;
        next_d     = next_q;
        depth_d    = depth_q;
        sp_d       = sp_q;
        spill_we   = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        if (accept && chk_code != '0) begin
            err_d      = 1'b1;
            err_code_d = chk_code;
        end
        if (state_q == EXEC) begin
            done_d = 1'b1;
            case (op_q)
                OP_PUSH, OP_DUP: begin
                    // NEXT only spills once it holds a live entry.
                    if (ge2) begin
                        spill_we = 1'b1;
                        sp_d     = sp_q + SP_W'(1);
                    end
                    next_d  = tos_q;
                    tos_d   = (op_q == OP_PUSH) ? imm_q : tos_q;
                    depth_d = depth_q + CNT_W'(1);
                end
                OP_DROP, OP_ALU_POP: begin
                    tos_d = (op_q == OP_DROP) ? next_q : alu_o_tos;
                    if (ge3) begin
                        next_d = spill_rd;
                        sp_d   = sp_q - SP_W'(1);
                    end else begin
                        next_d = '0;
                    end
                    depth_d = depth_q - CNT_W'(1);
                end
                OP_SWAP: begin
                    tos_d  = next_q;
                    next_d = tos_q;
                end
                OP_ALU_KEEP: begin
                    tos_d  = alu_o_tos;
                    next_d = alu_o_next;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_NOP;
            sel_q      <= '0;
            imm_q      <= '0;
            tos_q      <= '0;
            next_q     <= '0;
            depth_q    <= '0;
            sp_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            if (accept && chk_code == '0) begin
                op_q  <= op_t'(cmd_op);
                sel_q <= cmd_sel;
                imm_q <= cmd_imm;
            end
            tos_q      <= tos_d;
            next_q     <= next_d;
            depth_q    <= depth_d;
            sp_q       <= sp_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (spill_we) spill_q[spill_wr_idx] <= next_q;
    end

    assign alu_tos    = tos_q;
    assign alu_next   = next_q;
    assign alu_select = sel_q;
    assign tos        = tos_q;
    assign next       = next_q;
    assign depth      = depth_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_stack_exec_seq.sv
// Directed bench for stack_exec_seq: hand-computed expectations for push/pop,
// ALU writeback, depth limits, error codes and mid-command reset.
module tb_stack_exec_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_sel;
    logic [15:0] cmd_imm;
    logic [15:0] alu_tos, alu_next, alu_o_tos, alu_o_next;
    logic [3:0]  alu_select;
    logic [15:0] tos, next;
    logic [4:0]  depth;
    logic        done, err;
    logic [1:0]  err_code;
    logic        alu_mode;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, DROP = 3'b010, DUP = 3'b011,
                           SWAP = 3'b100, APOP = 3'b101, AKEEP = 3'b110, RSVD = 3'b111;

    stack_exec_seq #(.WIDTH(16), .DEPTH(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_sel    (cmd_sel),
        .cmd_imm    (cmd_imm),
        .alu_tos    (alu_tos),
        .alu_next   (alu_next),
        .alu_select (alu_select),
        .alu_o_tos  (alu_o_tos),
        .alu_o_next (alu_o_next),
        .tos        (tos),
        .next       (next),
        .depth      (depth),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    // ALU stub: mode 0 adds, mode 1 inverts TOS and copies TOS into NEXT.
    assign alu_o_tos  = alu_mode ? ~alu_tos : alu_tos + alu_next;
    assign alu_o_next = alu_mode ? alu_tos  : alu_next;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [15:0] t, input logic [15:0] n,
                             input logic [4:0] d);
        chk({tag, ".tos"}, 32'(tos), 32'(t));
        chk({tag, ".next"}, 32'(next), 32'(n));
        chk({tag, ".depth"}, 32'(depth), 32'(d));
    endtask

    // Issues one command; legal ones are checked through EXEC and the done pulse,
    // rejected ones for the err pulse with the given code.
    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [3:0] sel,
                          input logic [15:0] imm, input logic ok, input logic [1:0] ecode);
        @(negedge clk);
        chk({tag, ".ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_sel   = sel;
        cmd_imm   = imm;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_imm   = 16'hDEAD;
        cmd_sel   = 4'hF;
        if (ok) begin
            chk({tag, ".ready_exec"}, 32'(cmd_ready), 32'd0);
            chk({tag, ".sel_exec"}, 32'(alu_select), 32'(sel));
            chk({tag, ".done_exec"}, 32'(done), 32'd0);
            @(posedge clk);
            #1;
            chk({tag, ".done"}, 32'(done), 32'd1);
            chk({tag, ".ready_back"}, 32'(cmd_ready), 32'd1);
        end else begin
            chk({tag, ".err"}, 32'(err), 32'd1);
            chk({tag, ".err_code"}, 32'(err_code), 32'(ecode));
            chk({tag, ".no_done"}, 32'(done), 32'd0);
            chk({tag, ".ready_rej"}, 32'(cmd_ready), 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; cmd_sel = '0; cmd_imm = '0; alu_mode = 1'b0;
        #12;
        chk_state("reset", 16'h0, 16'h0, 5'd0);
        chk("reset.ready", 32'(cmd_ready), 32'd1);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.err", 32'(err), 32'd0);
        chk("reset.err_code", 32'(err_code), 32'd0);
        chk("reset.sel", 32'(alu_select), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back PUSHes with valid held: imm change during EXEC is ignored
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = PUSH; cmd_imm = 16'hFFFF;
        @(posedge clk); #1;
        chk("b2b.ready_exec", 32'(cmd_ready), 32'd0);
        cmd_imm = 16'h003F;
        @(posedge clk); #1;
        chk("b2b.done1", 32'(done), 32'd1);
        chk("b2b.tos1", 32'(tos), 32'h0000FFFF);
        chk("b2b.ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        chk("b2b.ready_exec2", 32'(cmd_ready), 32'd0);
        chk("b2b.no_done", 32'(done), 32'd0);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b.done2", 32'(done), 32'd1);
        chk_state("b2b", 16'h003F, 16'hFFFF, 5'd2);

        // ALU_POP with add stub
        alu_mode = 1'b0;
        do_cmd("apop", APOP, 4'b0001, 16'h0, 1'b1, 2'b00);
        chk_state("apop", 16'h003E, 16'h0000, 5'd1);

        // ALU_KEEP with invert stub on CCCC/1234
        do_cmd("drop0", DROP, 4'h0, 16'h0, 1'b1, 2'b00);
        chk_state("drop0", 16'h0, 16'h0, 5'd0);
        do_cmd("p1234", PUSH, 4'h0, 16'h1234, 1'b1, 2'b00);
        do_cmd("pcccc", PUSH, 4'h0, 16'hCCCC, 1'b1, 2'b00);
        alu_mode = 1'b1;
        do_cmd("akeep", AKEEP, 4'b1001, 16'h0, 1'b1, 2'b00);
        chk_state("akeep", 16'h3333, 16'hCCCC, 5'd2);
        alu_mode = 1'b0;

        // NOP leaves everything alone
        do_cmd("nop", NOP, 4'h2, 16'h5555, 1'b1, 2'b00);
        chk_state("nop", 16'h3333, 16'hCCCC, 5'd2);

        // Fill to capacity, overflow, then drain through the spill stack
        do_cmd("dr_a", DROP, 4'h0, 16'h0, 1'b1, 2'b00);
        do_cmd("dr_b", DROP, 4'h0, 16'h0, 1'b1, 2'b00);
        chk_state("empty", 16'h0, 16'h0, 5'd0);
        for (int i = 1; i <= 18; i++) do_cmd("fill", PUSH, 4'h0, 16'(i), 1'b1, 2'b00);
        chk_state("full", 16'd18, 16'd17, 5'd18);
        do_cmd("ovf", PUSH, 4'h0, 16'h0099, 1'b0, 2'b10);
        chk_state("ovf", 16'd18, 16'd17, 5'd18);
        do_cmd("dupovf", DUP, 4'h0, 16'h0, 1'b0, 2'b10);
        for (int k = 1; k <= 17; k++) begin
            do_cmd("drain", DROP, 4'h0, 16'h0, 1'b1, 2'b00);
            chk_state("drain", 16'(18 - k), 16'(17 - k), 5'(18 - k));
        end
        chk_state("drained", 16'd1, 16'd0, 5'd1);

        // Underflow and reserved-op rejection
        do_cmd("dr_c", DROP, 4'h0, 16'h0, 1'b1, 2'b00);
        do_cmd("unf_drop", DROP, 4'h0, 16'h0, 1'b0, 2'b01);
        chk_state("unf_drop", 16'h0, 16'h0, 5'd0);
        do_cmd("p5", PUSH, 4'h0, 16'h0005, 1'b1, 2'b00);
        do_cmd("unf_swap", SWAP, 4'h0, 16'h0, 1'b0, 2'b01);
        chk_state("unf_swap", 16'h5, 16'h0, 5'd1);
        do_cmd("rsvd", RSVD, 4'h0, 16'h0, 1'b0, 2'b11);
        @(posedge clk); #1;
        chk("err_pulse_end", 32'(err), 32'd0);
        chk("err_code_held", 32'(err_code), 32'd3);

        // DUP / SWAP / spill round trip
        do_cmd("dup", DUP, 4'h0, 16'h0, 1'b1, 2'b00);
        chk_state("dup", 16'h5, 16'h5, 5'd2);
        do_cmd("p7", PUSH, 4'h0, 16'h0007, 1'b1, 2'b00);
        do_cmd("swap", SWAP, 4'h0, 16'h0, 1'b1, 2'b00);
        chk_state("swap", 16'h5, 16'h7, 5'd3);
        do_cmd("dr_spill", DROP, 4'h0, 16'h0, 1'b1, 2'b00);
        chk_state("dr_spill", 16'h7, 16'h5, 5'd2);

        // Reset in the middle of a PUSH
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = PUSH; cmd_imm = 16'hABCD;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("mid.ready_exec", 32'(cmd_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_state("mid_rst", 16'h0, 16'h0, 5'd0);
        chk("mid_rst.ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst.done", 32'(done), 32'd0);
        chk("mid_rst.err_code", 32'(err_code), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst.done1", 32'(done), 32'd0);
        @(posedge clk); #1;
        chk("post_rst.done2", 32'(done), 32'd0);
        chk_state("post_rst", 16'h0, 16'h0, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
